// File: rtl/plic_claim_arbiter_pkg.sv
// Shared types and helpers for the PLIC claim/complete arbiter and its gateways.
package plic_claim_arbiter_pkg;

    typedef enum logic [1:0] {
        GW_IDLE      = 2'd0,
        GW_PENDING   = 2'd1,
        GW_INSERVICE = 2'd2
    } gw_state_t;

    localparam int PLIC_ID_NONE = 0;

    // IDs run 1..i_cnt with 0 reserved for "no interrupt".
    function automatic int plic_id_w(input int i_cnt);
        return $clog2(i_cnt + 1);
    endfunction

endpackage

// File: rtl/plic_gateway.sv
// One interrupt source gateway: input synchroniser, edge/level event, IDLE/PENDING/INSERVICE
// state and a one-deep missed-edge bit.
module plic_gateway
    import plic_claim_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      src_i,
    input  logic      edge_cfg_i,
    input  logic      claim_win_i,
    input  logic      complete_hit_i,
    output gw_state_t state_o
);

    logic      src_q;
    logic      src_q2;
    logic      missed_q;
    logic      missed_d;
    logic      event_w;
    gw_state_t state_q;
    gw_state_t state_d;

    assign event_w = edge_cfg_i ? (src_q & ~src_q2) : src_q;
    assign state_o = state_q;

    // Order matters: completion first, then a claim win, then the event is judged
    // against the resulting state (so a level source re-pends in the completing cycle).
    always_comb begin
        state_d  = state_q;
        missed_d = missed_q;
        if (complete_hit_i && state_q == GW_INSERVICE) begin
            state_d  = (edge_cfg_i && missed_q) ? GW_PENDING : GW_IDLE;
            missed_d = 1'b0;
        end
        if (claim_win_i && state_q == GW_PENDING) begin
            state_d = GW_INSERVICE;
        end
        if (event_w) begin
            if (state_d == GW_IDLE) begin
                state_d = GW_PENDING;
            end else if (state_d == GW_INSERVICE && edge_cfg_i) begin
                missed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q    <= 1'b0;
            src_q2   <= 1'b0;
            state_q  <= GW_IDLE;
            missed_q <= 1'b0;
        end else begin
            src_q    <= src_i;
            src_q2   <= src_q;
            state_q  <= state_d;
            missed_q <= missed_d;
        end
    end

endmodule

// File: rtl/plic_claim_arbiter.sv
// PLIC priority arbiter: per-source gateways, highest-priority-above-threshold winner
// with round-robin tie break, and the claim/complete sequencer.
module plic_claim_arbiter
    import plic_claim_arbiter_pkg::*;
#(
    parameter int I_CNT  = 8,
    parameter int PRIO_W = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [I_CNT-1:0]              src_i,
    input  logic [I_CNT-1:0]              edge_cfg_i,
    input  logic [I_CNT-1:0]              ie_i,
    input  logic [I_CNT*PRIO_W-1:0]       prio_i,
    input  logic [PRIO_W-1:0]             threshold_i,
    input  logic                          claim_i,
    input  logic                          complete_i,
    input  logic [plic_id_w(I_CNT)-1:0]   complete_id_i,
    output logic                          irq_o,
    output logic                          claim_valid_o,
    output logic [plic_id_w(I_CNT)-1:0]   claim_id_o,
    output logic [I_CNT-1:0]              pending_o
);

    localparam int ID_W = plic_id_w(I_CNT);

    // Handshake: claim_i is a one-cycle strobe answered by claim_valid_o/claim_id_o exactly
    // one cycle later (ID 0 when nothing is eligible); complete_i is a one-cycle strobe with
    // complete_id_i, silently ignored unless that ID is currently in service.

    gw_state_t         gw_state [I_CNT];
    logic [PRIO_W-1:0] prio     [I_CNT];
    logic [I_CNT-1:0]  eligible;
    logic [I_CNT-1:0]  top_mask;
    logic [I_CNT-1:0]  claim_win;
    logic [I_CNT-1:0]  complete_hit;
    logic [PRIO_W-1:0] best_prio;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   rr_ptr_q;
    logic              found;
    int                cand;

    for (genvar k = 0; k < I_CNT; k++) begin : g_src
        assign prio[k]         = prio_i[k*PRIO_W +: PRIO_W];
        assign pending_o[k]    = (gw_state[k] == GW_PENDING);
        assign eligible[k]     = pending_o[k] & ie_i[k] & (prio[k] > threshold_i);
        assign top_mask[k]     = eligible[k] & (prio[k] == best_prio);
        assign claim_win[k]    = claim_i & (winner == ID_W'(k + 1));
        assign complete_hit[k] = complete_i & (complete_id_i == ID_W'(k + 1));

        plic_gateway u_gateway (
            .clk            (clk),
            .reset          (reset),
            .src_i          (src_i[k]),
            .edge_cfg_i     (edge_cfg_i[k]),
            .claim_win_i    (claim_win[k]),
            .complete_hit_i (complete_hit[k]),
            .state_o        (gw_state[k])
        );
    end

    assign irq_o = |eligible;

    always_comb begin
        best_prio = '0;
        for (int k = 0; k < I_CNT; k++) begin
            if (eligible[k] && prio[k] > best_prio) begin
                best_prio = prio[k];
            end
        end
    end

    // Scan IDs rr_ptr+1, rr_ptr+2, ... wrapping I_CNT -> 1; first top-priority hit wins.
    always_comb begin
        winner = ID_W'(PLIC_ID_NONE);
        found  = 1'b0;
        cand   = 0;
        for (int i = 1; i <= I_CNT; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand > I_CNT) begin
                cand = cand - I_CNT;
            end
            for (int k = 0; k < I_CNT; k++) begin
                if (!found && cand == k + 1 && top_mask[k]) begin
                    found  = 1'b1;
                    winner = ID_W'(k + 1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q      <= '0;
            claim_valid_o <= 1'b0;
            claim_id_o    <= '0;
        end else begin
            claim_valid_o <= claim_i;
            if (claim_i) begin
                claim_id_o <= winner;
                if (winner != ID_W'(PLIC_ID_NONE)) begin
                    rr_ptr_q <= winner;
                end
            end
        end
    end

endmodule

// File: tb/tb_plic_claim_arbiter.sv
// Randomized and directed bench for plic_claim_arbiter against a behavioural PLIC model.
module tb_plic_claim_arbiter;

    localparam int N  = 8;
    localparam int PW = 3;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  src_i, edge_cfg_i, ie_i;
    logic [N*PW-1:0] prio_i;
    logic [PW-1:0] threshold_i;
    logic          claim_i, complete_i;
    logic [IW-1:0] complete_id_i;
    logic          irq_o, claim_valid_o;
    logic [IW-1:0] claim_id_o;
    logic [N-1:0]  pending_o;

    always #5 clk = ~clk;

    plic_claim_arbiter #(.I_CNT(N), .PRIO_W(PW)) dut (
        .clk(clk), .reset(reset), .src_i(src_i), .edge_cfg_i(edge_cfg_i), .ie_i(ie_i),
        .prio_i(prio_i), .threshold_i(threshold_i), .claim_i(claim_i), .complete_i(complete_i),
        .complete_id_i(complete_id_i), .irq_o(irq_o), .claim_valid_o(claim_valid_o),
        .claim_id_o(claim_id_o), .pending_o(pending_o)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [IW-1:0] exp_q[$];

    // Model: 0 = idle, 1 = pending, 2 = in service
    int m_st[N];
    bit m_ms[N];
    bit m_sq[N];
    bit m_sq2[N];
    int m_rr = 0;
    bit m_cv = 0;
    bit m_rst = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int m_prio(input int id);
        return int'(prio_i[(id-1)*PW +: PW]);
    endfunction

    function automatic bit m_elig(input int id);
        return m_st[id-1] == 1 && ie_i[id-1] && m_prio(id) > int'(threshold_i);
    endfunction

    // Highest priority wins; among equals, the smallest forward distance from rr wins.
    function automatic int m_winner();
        int best, bp, bd, d;
        best = 0; bp = 0; bd = N;
        for (int id = 1; id <= N; id++) begin
            if (m_elig(id)) begin
                d = (id - m_rr - 1 + 2*N) % N;
                if (m_prio(id) > bp || (m_prio(id) == bp && d < bd)) begin
                    best = id; bp = m_prio(id); bd = d;
                end
            end
        end
        return best;
    endfunction

    function automatic bit m_irq();
        bit r;
        r = 0;
        for (int id = 1; id <= N; id++) if (m_elig(id)) r = 1;
        return r;
    endfunction

    function automatic logic [N-1:0] m_pend();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = (m_st[k] == 1);
        return v;
    endfunction

    task automatic model_step();
        int win, ns;
        bit ms, ev, ed;
        m_rst = reset;
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                m_st[k] = 0; m_ms[k] = 0; m_sq[k] = 0; m_sq2[k] = 0;
            end
            m_rr = 0; m_cv = 0;
            exp_q.delete();
            return;
        end
        win = m_winner();
        for (int k = 0; k < N; k++) begin
            ed = edge_cfg_i[k];
            ev = ed ? (m_sq[k] && !m_sq2[k]) : m_sq[k];
            ns = m_st[k]; ms = m_ms[k];
            if (complete_i && int'(complete_id_i) == k + 1 && ns == 2) begin
                ns = (ed && ms) ? 1 : 0;
                ms = 0;
            end
            if (claim_i && win == k + 1) ns = 2;
            if (ev && ns == 0) ns = 1;
            else if (ev && ns == 2 && ed) ms = 1;
            m_st[k] = ns; m_ms[k] = ms;
            m_sq2[k] = m_sq[k]; m_sq[k] = src_i[k];
        end
        m_cv = claim_i;
        if (claim_i) begin
            exp_q.push_back(IW'(win));
            if (win != 0) m_rr = win;
        end
    endtask

    // One clock: update model with the inputs now applied, then compare after the edge.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_eq("claim_valid", claim_valid_o, m_cv);
        if (claim_valid_o === 1'b1) begin
            check_eq("claim_q_size", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check_eq("claim_id", claim_id_o, exp_q.pop_front());
        end
        exp_q.delete();
        if (m_rst) check_eq("rst_claim_id", claim_id_o, 0);
        check_eq("irq", irq_o, m_irq());
        check_eq("pending", pending_o, m_pend());
        @(negedge clk);
    endtask

    task automatic claim_once();
        claim_i = 1'b1; step(); claim_i = 1'b0;
    endtask

    task automatic complete_one(input int id);
        complete_i = 1'b1; complete_id_i = IW'(id); step(); complete_i = 1'b0;
    endtask

    task automatic set_prio(input int id, input int p);
        prio_i[(id-1)*PW +: PW] = PW'(p);
    endtask

    task automatic do_reset();
        reset = 1'b1; step(); reset = 1'b0;
    endtask

    initial begin
        int svc[$];
        int id;
        reset = 1'b1; src_i = '0; edge_cfg_i = '0; ie_i = '1; prio_i = '0; threshold_i = '0;
        claim_i = 1'b0; complete_i = 1'b0; complete_id_i = '0;
        @(negedge clk);
        step(); step();
        check_eq("reset_irq", irq_o, 0);
        check_eq("reset_pending", pending_o, 0);
        reset = 1'b0;

        // Level source ID3, two-edge latency and re-pend on complete
        set_prio(3, 2);
        src_i[2] = 1'b1;
        step();
        check_eq("lvl_lat1", irq_o, 0);
        step();
        check_eq("lvl_lat2", irq_o, 1);
        claim_once();
        check_eq("lvl_claim", claim_id_o, 3);
        check_eq("lvl_irq_svc", irq_o, 0);
        complete_one(3);
        check_eq("lvl_repend", irq_o, 1);
        src_i[2] = 1'b0;
        step(); claim_once(); complete_one(3); step();

        // Priority ordering
        prio_i = '0; set_prio(2, 1); set_prio(5, 4);
        src_i = 8'b0001_0010; step(); step(); src_i = '0;
        claim_once(); check_eq("prio_1st", claim_id_o, 5);
        claim_once(); check_eq("prio_2nd", claim_id_o, 2);
        claim_once(); check_eq("prio_none", claim_id_o, 0);
        check_eq("prio_none_valid", claim_valid_o, 1);
        complete_one(5); complete_one(2);

        // Round-robin ties, twice to cover the wrap from rr=6
        do_reset();
        prio_i = '0; set_prio(1, 3); set_prio(4, 3); set_prio(6, 3);
        for (int r = 0; r < 2; r++) begin
            src_i = 8'b0010_1001; step(); step(); src_i = '0;
            claim_once(); check_eq("rr_a", claim_id_o, 1);
            claim_once(); check_eq("rr_b", claim_id_o, 4);
            claim_once(); check_eq("rr_c", claim_id_o, 6);
            complete_one(1); complete_one(4); complete_one(6); step();
        end

        // Threshold and enable
        prio_i = '0; set_prio(7, 2); threshold_i = 3'd2;
        src_i[6] = 1'b1; step(); step(); src_i = '0;
        check_eq("thr_block", irq_o, 0);
        threshold_i = 3'd1; step();
        check_eq("thr_pass", irq_o, 1);
        ie_i[6] = 1'b0; step();
        check_eq("ie_block", irq_o, 0);
        check_eq("ie_pend_kept", pending_o[6], 1);
        ie_i = '1; claim_once(); check_eq("thr_claim", claim_id_o, 7);
        complete_one(7); threshold_i = '0;

        // Edge mode with missed edge
        prio_i = '0; set_prio(4, 4); edge_cfg_i[3] = 1'b1;
        src_i[3] = 1'b1; step(); src_i[3] = 1'b0; step(); step();
        claim_once(); check_eq("edge_claim1", claim_id_o, 4);
        for (int p = 0; p < 2; p++) begin
            src_i[3] = 1'b1; step(); src_i[3] = 1'b0; step();
        end
        step();
        complete_one(4); check_eq("edge_missed_pend", pending_o[3], 1);
        claim_once(); check_eq("edge_claim2", claim_id_o, 4);
        complete_one(4); step(); check_eq("edge_lost", pending_o[3], 0);
        complete_one(4); complete_one(9); step();
        edge_cfg_i = '0;

        // Reset together with a claim while ID2 in service and ID5 pending
        prio_i = '0; set_prio(2, 5); set_prio(5, 3);
        src_i = 8'b0001_0010; step(); step(); src_i = '0; step();
        claim_once(); check_eq("rst_pre_claim", claim_id_o, 2);
        reset = 1'b1; claim_i = 1'b1; step(); reset = 1'b0; claim_i = 1'b0;
        check_eq("rst_out_valid", claim_valid_o, 0);
        check_eq("rst_out_pend", pending_o, 0);
        step(); step();
        claim_once(); check_eq("rst_no_repend", claim_id_o, 0);
        set_prio(2, 3);
        src_i = 8'b0001_0010; step(); step(); src_i = '0;
        claim_once(); check_eq("rst_rr_zero", claim_id_o, 2);
        complete_one(2);

        // Randomized traffic
        for (int c = 0; c < 2500; c++) begin
            if (c % 250 == 0) begin
                edge_cfg_i = N'($urandom);
                prio_i = (N*PW)'($urandom);
                threshold_i = PW'($urandom_range(0, 2));
                ie_i = N'($urandom | $urandom);
            end
            src_i = src_i ^ N'($urandom & $urandom & $urandom);
            claim_i = ($urandom_range(0, 9) < 3);
            complete_i = ($urandom_range(0, 9) < 3);
            svc.delete();
            for (int k = 0; k < N; k++) if (m_st[k] == 2) svc.push_back(k + 1);
            if (svc.size() > 0 && $urandom_range(0, 1) == 1) id = svc[$urandom_range(0, svc.size() - 1)];
            else id = $urandom_range(0, 9);
            complete_id_i = IW'(id);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0; claim_i = 1'b0; complete_i = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
